// File: rtl/cnet_cpci_reg_slave_pkg.sv
// cnet_cpci_reg_slave_pkg: shared CPCI/CNET register bus widths, FSM encoding and timeout read data
package cnet_cpci_reg_slave_pkg;
  localparam int CPCI_CNET_ADDR_WIDTH = 27;
  localparam int CPCI_CNET_DATA_WIDTH = 32;
  localparam logic [31:0] CNET_TIMEOUT_DATA = 32'hDEAD_0001;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_TURN = 2'd3
  } reg_state_e;
endpackage

// File: rtl/cnet_reg_timeout.sv
// cnet_reg_timeout: load/enable wait counter flagging the terminal count CYCLES-1
module cnet_reg_timeout #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? '0 : en ? cnt_q + W'(1) : cnt_q;
  assign tc = en && (cnt_q == W'(CYCLES - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cnet_cpci_reg_slave.sv
// cnet_cpci_reg_slave: CPCI request to CNET register bus bridge; wait timeout enabled by CNET_REG_SLAVE_TIMEOUT_EN
module cnet_cpci_reg_slave
  import cnet_cpci_reg_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = CPCI_CNET_ADDR_WIDTH,
  parameter int DATA_WIDTH = CPCI_CNET_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(CNET_TIMEOUT_DATA)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpci_req,
  input  logic                  cpci_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] cpci_addr,
  input  logic [DATA_WIDTH-1:0] cpci_data_in,
  output logic [DATA_WIDTH-1:0] cpci_data_out,
  output logic                  cpci_data_tri_en,
  output logic                  cpci_wr_rdy,
  output logic                  cpci_rd_rdy,
  output logic                  reg_req,
  output logic                  reg_rd_wr_L,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic                  reg_ack,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  reg_timeout
);
  reg_state_e state_q, state_d;
  logic req_q, rd_wr_L_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic reg_req_q, reg_req_d, reg_rd_wr_L_q, reg_rd_wr_L_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d, dout_q, dout_d;
  logic tri_en_q, tri_en_d, wr_rdy_q, wr_rdy_d, rd_rdy_q, rd_rdy_d, timeout_q, timeout_d;
  logic tc;
`ifdef CNET_REG_SLAVE_TIMEOUT_EN
  cnet_reg_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk  (clk),
    .reset(reset),
    .load (state_q != ST_WAIT),
    .en   (state_q == ST_WAIT),
    .tc   (tc)
  );
`else
  assign tc = 1'b0;
`endif
  always_comb begin
    state_d       = state_q;
    reg_req_d     = reg_req_q;
    reg_rd_wr_L_d = reg_rd_wr_L_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    dout_d        = dout_q;
    tri_en_d      = 1'b0;
    wr_rdy_d      = 1'b0;
    rd_rdy_d      = 1'b0;
    timeout_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (req_q) begin
        state_d       = ST_WAIT;
        reg_req_d     = 1'b1;
        reg_rd_wr_L_d = rd_wr_L_q;
        reg_addr_d    = addr_q;
        reg_wr_data_d = din_q;
      end
      ST_WAIT: if (reg_ack || tc) begin
        state_d   = ST_RESP;
        reg_req_d = 1'b0;
        wr_rdy_d  = !reg_rd_wr_L_q;
        rd_rdy_d  = reg_rd_wr_L_q;
        tri_en_d  = reg_rd_wr_L_q;
        timeout_d = !reg_ack;
        dout_d    = !reg_rd_wr_L_q ? dout_q : reg_ack ? reg_rd_data : TIMEOUT_DATA;
      end
      ST_RESP: state_d = ST_TURN;
      default: state_d = ST_IDLE;
    endcase
  end
  // TURN ignores req_q so a req still in the input flop after rdy is not seen twice
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      req_q         <= 1'b0;
      rd_wr_L_q     <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      state_q       <= ST_IDLE;
      reg_req_q     <= 1'b0;
      reg_rd_wr_L_q <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      dout_q        <= '0;
      tri_en_q      <= 1'b0;
      wr_rdy_q      <= 1'b0;
      rd_rdy_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      req_q         <= cpci_req;
      rd_wr_L_q     <= cpci_rd_wr_L;
      addr_q        <= cpci_addr;
      din_q         <= cpci_data_in;
      state_q       <= state_d;
      reg_req_q     <= reg_req_d;
      reg_rd_wr_L_q <= reg_rd_wr_L_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      dout_q        <= dout_d;
      tri_en_q      <= tri_en_d;
      wr_rdy_q      <= wr_rdy_d;
      rd_rdy_q      <= rd_rdy_d;
      timeout_q     <= timeout_d;
    end
  assign cpci_data_out    = dout_q;
  assign cpci_data_tri_en = tri_en_q;
  assign cpci_wr_rdy      = wr_rdy_q;
  assign cpci_rd_rdy      = rd_rdy_q;
  assign reg_req          = reg_req_q;
  assign reg_rd_wr_L      = reg_rd_wr_L_q;
  assign reg_addr         = reg_addr_q;
  assign reg_wr_data      = reg_wr_data_q;
  assign reg_timeout      = timeout_q;
endmodule
